// File: rtl/bip_control_unit_if.sv
// bip_control_unit_if: sequencer-to-memory/datapath bus; BIP_INSTR_COUNTER_EN adds InstrCount.
interface bip_control_unit_if #(
   parameter int AB = 11,
   parameter int DB = 16
);
   logic          Start;
   logic [DB-1:0] Instr;
   logic [AB-1:0] Addr_PM;
   logic [AB-1:0] Addr;
   logic [1:0]    SelA;
   logic          SelB;
   logic          WrAcc;
   logic          Op;
   logic          Clear;
   logic          WrRam;
   logic          RdRam;
   logic          Halted;
`ifdef BIP_INSTR_COUNTER_EN
   logic [31:0]   InstrCount;
   modport master (input Start, Instr, output Addr_PM, Addr, SelA, SelB, WrAcc, Op, Clear, WrRam, RdRam, Halted, InstrCount);
   modport slave (output Start, Instr, input Addr_PM, Addr, SelA, SelB, WrAcc, Op, Clear, WrRam, RdRam, Halted, InstrCount);
`else
   modport master (input Start, Instr, output Addr_PM, Addr, SelA, SelB, WrAcc, Op, Clear, WrRam, RdRam, Halted);
   modport slave (output Start, Instr, input Addr_PM, Addr, SelA, SelB, WrAcc, Op, Clear, WrRam, RdRam, Halted);
`endif
endinterface

// File: rtl/bip_control_unit.sv
// bip_control_unit: BIP-I sequencer (fetch/exec/writeback until HLT).
// Optional BIP_INSTR_COUNTER_EN adds a saturating executed-instruction counter.
module bip_control_unit #(
   parameter int AB = 11,
   parameter int DB = 16
) (
   input logic clk,
   input logic Reset,
   bip_control_unit_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} state_t;
   localparam logic [DB-AB-1:0] OP_HLT  = 'd0;
   localparam logic [DB-AB-1:0] OP_STO  = 'd1;
   localparam logic [DB-AB-1:0] OP_LD   = 'd2;
   localparam logic [DB-AB-1:0] OP_LDI  = 'd3;
   localparam logic [DB-AB-1:0] OP_ADD  = 'd4;
   localparam logic [DB-AB-1:0] OP_ADDI = 'd5;
   localparam logic [DB-AB-1:0] OP_SUB  = 'd6;
   localparam logic [DB-AB-1:0] OP_SUBI = 'd7;
   state_t state, state_nx;
   logic [AB-1:0] pc;
   logic [DB-1:0] ir;
   logic [DB-AB-1:0] opc;
   logic exec;
   // EXEC decodes the memory word as it arrives; WB relies on the copy latched into ir
   assign exec = state == EXEC;
   assign opc = exec ? bus.Instr[DB-1:AB] : ir[DB-1:AB];
   assign bus.Addr_PM = pc;
   assign bus.Addr = exec ? bus.Instr[AB-1:0] : ir[AB-1:0];
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         pc <= '0;
         ir <= '0;
      end else begin
         state <= state_nx;
         if (exec) begin
            ir <= bus.Instr;
            if (opc != OP_HLT) pc <= pc + 1'b1;
         end
      end
   end
   always_comb begin
      state_nx = state;
      bus.SelA = 2'd0;
      bus.SelB = 1'b0;
      bus.WrAcc = 1'b0;
      bus.Op = 1'b0;
      bus.Clear = 1'b0;
      bus.WrRam = 1'b0;
      bus.RdRam = 1'b0;
      bus.Halted = 1'b0;
      case (state)
         IDLE: begin
            bus.Clear = 1'b1;
            state_nx = bus.Start ? FETCH : IDLE;
         end
         FETCH: state_nx = EXEC;
         EXEC: begin
            state_nx = FETCH;
            case (opc)
               OP_HLT: state_nx = HALT;
               OP_STO: bus.WrRam = 1'b1;
               OP_LD, OP_ADD, OP_SUB: begin
                  bus.RdRam = 1'b1;
                  state_nx = WB;
               end
               OP_LDI: begin
                  bus.SelA = 2'd1;
                  bus.WrAcc = 1'b1;
               end
               OP_ADDI: begin
                  bus.Op = 1'b1;
                  bus.WrAcc = 1'b1;
               end
               OP_SUBI: bus.WrAcc = 1'b1;
               default: ;
            endcase
         end
         WB: begin
            state_nx = FETCH;
            bus.WrAcc = 1'b1;
            bus.SelA = opc == OP_LD ? 2'd2 : 2'd0;
            bus.SelB = opc != OP_LD;
            bus.Op = opc == OP_ADD;
         end
         HALT: bus.Halted = 1'b1;
         default: state_nx = IDLE;
      endcase
   end
`ifdef BIP_INSTR_COUNTER_EN
   logic [31:0] cnt;
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) cnt <= '0;
      else if (state == IDLE) cnt <= '0;
      else if (exec && opc != OP_HLT && cnt != '1) cnt <= cnt + 1'b1;
   end
   assign bus.InstrCount = cnt;
`endif
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: random and directed programs checked cycle-by-cycle against a program-level trace model.
module tb_bip_control_unit;
   typedef struct packed {
      logic [10:0] addr_pm;
      logic [10:0] addr;
      logic        addr_care;
      logic [1:0]  sela;
      logic        selb;
      logic        wracc;
      logic        op;
      logic        clear;
      logic        wrram;
      logic        rdram;
      logic        halted;
   } exp_t;
   logic clk = 1'b0;
   logic Reset;
   logic [15:0] prog [0:2047];
   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int exp_count;
   bit ends_halted;
   bip_control_unit_if bus ();
   bip_control_unit dut (.clk(clk), .Reset(Reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) bus.Instr <= prog[bus.Addr_PM];

   function automatic exp_t blank(int pc);
      exp_t e;
      e = '0;
      e.addr_pm = 11'(pc);
      return e;
   endfunction

   function automatic exp_t observe(exp_t e);
      exp_t a;
      a = e;
      a.addr_pm = bus.Addr_PM;
      if (e.addr_care) a.addr = bus.Addr;
      a.sela = bus.SelA;
      a.selb = bus.SelB;
      a.wracc = bus.WrAcc;
      a.op = bus.Op;
      a.clear = bus.Clear;
      a.wrram = bus.WrRam;
      a.rdram = bus.RdRam;
      a.halted = bus.Halted;
      return a;
   endfunction

   // Expands the program into the expected per-cycle outputs from the instruction rules
   task automatic build(int limit);
      int pc;
      logic [15:0] w;
      logic [4:0] o;
      exp_t e;
      pc = 0;
      q.delete();
      exp_count = 0;
      ends_halted = 0;
      while (q.size() < limit) begin
         w = prog[pc];
         o = w[15:11];
         q.push_back(blank(pc));
         e = blank(pc);
         e.addr = w[10:0];
         e.addr_care = 1'b1;
         case (o)
            5'd1: e.wrram = 1'b1;
            5'd2, 5'd4, 5'd6: e.rdram = 1'b1;
            5'd3: begin e.sela = 2'd1; e.wracc = 1'b1; end
            5'd5: begin e.op = 1'b1; e.wracc = 1'b1; end
            5'd7: e.wracc = 1'b1;
            default: ;
         endcase
         q.push_back(e);
         if (o == 5'd0) begin
            e = blank(pc);
            e.halted = 1'b1;
            repeat (3) q.push_back(e);
            ends_halted = 1;
            break;
         end
         exp_count++;
         pc = (pc + 1) % 2048;
         if (o == 5'd2 || o == 5'd4 || o == 5'd6) begin
            e = blank(pc);
            e.addr = w[10:0];
            e.addr_care = 1'b1;
            e.wracc = 1'b1;
            e.sela = o == 5'd2 ? 2'd2 : 2'd0;
            e.selb = o != 5'd2;
            e.op = o == 5'd4;
            q.push_back(e);
         end
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      bus.Start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      Reset = 1'b0;
   endtask

   task automatic run(string name, int limit);
      exp_t a;
      build(limit);
      do_reset();
      @(negedge clk);
      bus.Start = 1'b1;
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         bus.Start = 1'b0;
         a = observe(q[i]);
         checks++;
         if (a !== q[i]) begin
            failures++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, i, a, q[i]);
         end
      end
`ifdef BIP_INSTR_COUNTER_EN
      if (ends_halted) begin
         checks++;
         if (bus.InstrCount !== 32'(exp_count)) begin
            failures++;
            $display("FAIL %s InstrCount: got %0d expected %0d", name, bus.InstrCount, exp_count);
         end
      end
`endif
   endtask

   task automatic fill(logic [15:0] w);
      for (int i = 0; i < 2048; i++) prog[i] = w;
   endtask

   task automatic test_reset();
      exp_t e;
      e = blank(0);
      e.clear = 1'b1;
      e.addr_care = 1'b1;
      Reset = 1'b1;
      bus.Start = 1'b0;
      #1;
      checks++;
      if (observe(e) !== e) begin
         failures++;
         $display("FAIL reset_state: got %h expected %h", observe(e), e);
      end
      @(negedge clk);
      Reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (observe(e) !== e) begin
         failures++;
         $display("FAIL idle_hold: got %h expected %h", observe(e), e);
      end
`ifdef BIP_INSTR_COUNTER_EN
      checks++;
      if (bus.InstrCount !== 32'd0) begin
         failures++;
         $display("FAIL reset_count: got %0d expected 0", bus.InstrCount);
      end
`endif
   endtask

   task automatic test_immediate();
      fill(16'h0000);
      prog[0] = {5'd3, 11'd5};
      prog[1] = {5'd5, 11'd3};
      run("immediate", 100);
   endtask

   task automatic test_memops();
      fill(16'h0000);
      prog[0] = {5'd2, 11'h010};
      prog[1] = {5'd6, 11'h011};
      prog[2] = {5'd1, 11'h012};
      run("memops", 100);
   endtask

   task automatic test_nop();
      fill(16'h0000);
      prog[0] = {5'h1f, 11'h155};
      run("nop", 100);
   endtask

   task automatic test_counter_four();
      fill(16'h0000);
      prog[0] = {5'd3, 11'd1};
      prog[1] = {5'd4, 11'd2};
      prog[2] = {5'h1a, 11'd3};
      prog[3] = {5'd1, 11'd4};
      run("four_instr", 100);
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         fill(16'h0000);
         for (int i = 0; i < 10; i++) prog[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
         run($sformatf("random%0d", r), 200);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      fill(16'h0000);
      prog[0] = {5'd4, 11'h020};
      do_reset();
      @(negedge clk);
      bus.Start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         bus.Start = 1'b0;
      end
      checks++;
      if (bus.WrAcc !== 1'b1) begin
         failures++;
         $display("FAIL add_wb_wracc: got %b expected 1", bus.WrAcc);
      end
      Reset = 1'b1;
      #1;
      checks++;
      if ({bus.WrAcc, bus.RdRam, bus.Clear, bus.Addr_PM} !== {1'b0, 1'b0, 1'b1, 11'd0}) begin
         failures++;
         $display("FAIL reset_abort: got wracc=%b rdram=%b clear=%b pc=%h expected 0 0 1 000", bus.WrAcc, bus.RdRam, bus.Clear, bus.Addr_PM);
      end
      @(negedge clk);
      Reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.Clear, bus.WrAcc, bus.Addr_PM} !== {1'b1, 1'b0, 11'd0}) begin
         failures++;
         $display("FAIL reset_idle: got clear=%b wracc=%b pc=%h expected 1 0 000", bus.Clear, bus.WrAcc, bus.Addr_PM);
      end
      bus.Start = 1'b1;
      n = 0;
      while (bus.Halted !== 1'b1 && n < 20) begin
         @(negedge clk);
         bus.Start = 1'b0;
         n++;
      end
      checks++;
      if (bus.Halted !== 1'b1) begin
         failures++;
         $display("FAIL halt_timeout: got halted=%b after %0d cycles expected 1", bus.Halted, n);
      end
      for (int i = 0; i < 4; i++) begin
         bus.Start = i[0];
         @(negedge clk);
         checks++;
         if ({bus.Halted, bus.Clear, bus.Addr_PM} !== {1'b1, 1'b0, 11'd1}) begin
            failures++;
            $display("FAIL halt_start_ignored: got halted=%b clear=%b pc=%h expected 1 0 001", bus.Halted, bus.Clear, bus.Addr_PM);
         end
      end
      bus.Start = 1'b0;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 2048; i++) prog[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
      run("pc_wrap", 2 * 2048 + 8);
   endtask

   initial begin
      Reset = 1'b1;
      bus.Start = 1'b0;
      fill(16'h0000);
      test_reset();
      test_immediate();
      test_memops();
      test_nop();
      test_counter_four();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Instruction sequencer directly upstream of the accumulator datapath.
- Holds the program counter and fetches instruction words from a synchronous program memory.
- Decodes each word and drives the datapath controls SelA/SelB/WrAcc/Op/Clear, the operand address and the data-memory strobes.
- Executes a BIP-I instruction set until HLT.

Parameters:
AB, 11, address width of program memory, data memory and instruction operand field
DB, 16, instruction word width; opcode = Instr[DB-1:AB] (5 bits at defaults)

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle pulse; leaves IDLE
Instr  in  DB  program memory read data, valid the cycle after Addr_PM is presented
Addr_PM  out  AB  program memory address (PC)
Addr  out  AB  operand field Instr[AB-1:0] to datapath / data memory
SelA  out  2  accumulator source: 0 ALU, 1 sign-extended operand, 2 data memory
SelB  out  1  ALU operand B: 0 sign-extended operand, 1 data memory
WrAcc  out  1  accumulator write enable
Op  out  1  1 add, 0 subtract
Clear  out  1  accumulator clear
WrRam  out  1  data memory write strobe
RdRam  out  1  data memory read strobe (synchronous read, data valid next cycle)
Halted  out  1  high while in HALT

Behaviour:
- Reset (async): state=IDLE, PC=0, IR=0. Outputs: Addr_PM=0, Addr=0, SelA=0, SelB=0, WrAcc=0, Op=0, Clear=1, WrRam=0, RdRam=0, Halted=0.
- States: IDLE, FETCH, EXEC, WB, HALT.
- IDLE:
  - Clear=1, all strobes 0.
  - Start=1 -> FETCH; otherwise stay in IDLE.
- FETCH:
  - Addr_PM=PC.
  - IR captures Instr at the end of EXEC's first edge; the memory is 1-cycle latency, so the decode in EXEC uses Instr directly, then latches it into IR.
  - Next state is always EXEC.
- EXEC: decode opcode from Instr; Addr=Instr[AB-1:0].
  - 00000 HLT: -> HALT; PC unchanged.
  - 00001 STO: WrRam=1 -> FETCH.
  - 00010 LD: RdRam=1 -> WB.
  - 00011 LDI: SelA=1, WrAcc=1 -> FETCH.
  - 00100 ADD: RdRam=1 -> WB.
  - 00101 ADDI: SelA=0, SelB=0, Op=1, WrAcc=1 -> FETCH.
  - 00110 SUB: RdRam=1 -> WB.
  - 00111 SUBI: SelA=0, SelB=0, Op=0, WrAcc=1 -> FETCH.
  - Any other opcode: NOP, no strobes -> FETCH.
  - PC increments at the EXEC edge for every opcode except HLT.
- WB: uses the latched IR; Addr=IR[AB-1:0]; RdRam=0. Next state is always FETCH.
  - LD: SelA=2, WrAcc=1.
  - ADD: SelA=0, SelB=1, Op=1, WrAcc=1.
  - SUB: SelA=0, SelB=1, Op=0, WrAcc=1.
- HALT: Halted=1, all strobes 0. Stays until Reset; Start is ignored.
- Strobes WrAcc/WrRam/RdRam are Moore-decoded and high for exactly one cycle per instruction. Clear is high only in IDLE.
- Instruction latency:
  - Immediate, STO and NOP: 2 cycles (FETCH, EXEC).
  - Memory-read ops (LD/ADD/SUB): 3 cycles.
  - Throughput: one instruction at a time, no overlap.
- PC wraps from 2^AB-1 to 0 with no flag.
- Reset mid-instruction: aborts immediately, no strobe completes after Reset rises, and the block returns to IDLE.
- Start asserted outside IDLE: ignored.

Optional Feature:
- Macro: BIP_INSTR_COUNTER_EN
- With the macro: adds output InstrCount (32 bits).
  - Increments by 1 on every EXEC cycle whose opcode is not HLT, including NOPs.
  - Async-cleared by Reset; also cleared in IDLE.
  - Saturates at 2^32-1.
  - Holds its value in HALT.
- Without the macro: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset then Start, program [LDI 5, ADDI 3, HLT] -> WrAcc pulses with SelA=1, then SelA=0/Op=1; Halted=1 after 6 cycles from Start; Addr_PM sequence 0,1,2.
- Program [LD 0x010, SUB 0x011, STO 0x012, HLT] -> for each of LD/SUB: RdRam in EXEC and WrAcc in WB one cycle later, with SelA=2 for LD and SelA=0/SelB=1/Op=0 for SUB. WrRam=1 with Addr=0x012 during STO EXEC.
- Opcode 11111 at PC=0 followed by HLT -> no strobes for the NOP; PC advances to 1; halts.
- Reset asserted during the WB of an ADD -> WrAcc drops in the same cycle (async); state=IDLE, PC=0, Clear=1; Start pulses in HALT are ignored.
- PC preloaded to 0x7FF by a program of NOPs -> after 0x7FF, Addr_PM=0x000.
- With BIP_INSTR_COUNTER_EN, program of 4 instructions + HLT -> InstrCount=4 and holds while Halted.
